// File: rtl/uart_tx_sched_if.sv
// Requester and uart-side signal bundle for uart_tx_sched.
// The scheduler connects through the slave modport; sources and the uart model use master.
interface uart_tx_sched_if #(
   parameter int NREQ = 4
);
   localparam int GW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              uart_transmit;
   logic [7:0]        uart_tx_byte;
   logic              uart_tx_free;
   logic              grant_valid;
   logic [GW-1:0]     grant_id;
   logic              abort;

   modport master (
      output req_valid, req_data, req_last, uart_tx_free,
      input  req_ready, uart_transmit, uart_tx_byte, grant_valid, grant_id, abort
   );

   modport slave (
      input  req_valid, req_data, req_last, uart_tx_free,
      output req_ready, uart_transmit, uart_tx_byte, grant_valid, grant_id, abort
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one uart transmitter among NREQ byte sources.
// Optional channel-tag prefix byte per packet: define UART_TX_SCHED_TAG_EN.
module uart_tx_sched #(
   parameter int         NREQ         = 4,
   parameter int         IDLE_TIMEOUT = 1024,
   parameter logic [7:0] TAG_BASE     = 8'hA0
) (
   input logic           clk,
   input logic           rst,
   uart_tx_sched_if.slave bus
);
   localparam int unsigned NR     = NREQ;
   localparam int          GW     = $clog2(NREQ);
   localparam int          TW     = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam bit          TMO_EN = (IDLE_TIMEOUT > 0);
   localparam logic [TW-1:0] TMO_LAST = (IDLE_TIMEOUT > 0) ? TW'(IDLE_TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_ISSUE,
      S_GUARD,
`ifdef UART_TX_SCHED_TAG_EN
      S_WAIT,
      S_TAG
`else
      S_WAIT
`endif
   } state_t;

   state_t        state;
   logic          last_q;
   logic [TW-1:0] tmo_cnt;
   logic [GW-1:0] grant_id;
   logic          grant_valid;
   logic          uart_transmit;
   logic [7:0]    uart_tx_byte;
   logic          abort;

   logic          cur_valid;
   logic          cur_last;
   logic [7:0]    cur_data;
   logic          accept;
   logic [GW-1:0] rr_pick;
   logic          rr_any;

   assign cur_valid = bus.req_valid[grant_id];
   assign cur_last  = bus.req_last[grant_id];
   assign cur_data  = bus.req_data[{grant_id, 3'b000} +: 8];
   assign accept    = (state == S_SEND) && cur_valid && bus.uart_tx_free;

   // Search starts one past the last grant, so the requester just served ranks lowest.
   always_comb begin
      rr_pick = grant_id;
      rr_any  = 1'b0;
      for (int unsigned k = 1; k <= NR; k++) begin
         int unsigned cand;
         cand = (32'(grant_id) + k) % NR;
         if (!rr_any && bus.req_valid[cand]) begin
            rr_any  = 1'b1;
            rr_pick = GW'(cand);
         end
      end
   end

   always_comb begin
      bus.req_ready           = '0;
      bus.req_ready[grant_id] = accept;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         last_q        <= 1'b0;
         tmo_cnt       <= '0;
         grant_id      <= GW'(NREQ - 1);
         grant_valid   <= 1'b0;
         uart_transmit <= 1'b0;
         uart_tx_byte  <= '0;
         abort         <= 1'b0;
      end else begin
         uart_transmit <= 1'b0;
         abort         <= 1'b0;
         case (state)
            S_IDLE: begin
               tmo_cnt <= '0;
               if (rr_any) begin
                  grant_id    <= rr_pick;
                  grant_valid <= 1'b1;
`ifdef UART_TX_SCHED_TAG_EN
                  state       <= S_TAG;
`else
                  state       <= S_SEND;
`endif
               end
            end
`ifdef UART_TX_SCHED_TAG_EN
            S_TAG: begin
               if (bus.uart_tx_free) begin
                  uart_tx_byte  <= {TAG_BASE[7:4], 4'(grant_id)};
                  last_q        <= 1'b0;
                  uart_transmit <= 1'b1;
                  state         <= S_ISSUE;
               end
            end
`endif
            S_SEND: begin
               if (accept) begin
                  uart_tx_byte  <= cur_data;
                  last_q        <= cur_last;
                  tmo_cnt       <= '0;
                  uart_transmit <= 1'b1;
                  state         <= S_ISSUE;
               end else if (!cur_valid && TMO_EN) begin
                  // A busy uart with data pending never counts toward the timeout.
                  if (tmo_cnt == TMO_LAST) begin
                     abort       <= 1'b1;
                     grant_valid <= 1'b0;
                     tmo_cnt     <= '0;
                     state       <= S_IDLE;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end
            end
            S_ISSUE: state <= S_GUARD;
            S_GUARD: state <= S_WAIT;
            S_WAIT: begin
               if (bus.uart_tx_free) begin
                  if (last_q) begin
                     grant_valid <= 1'b0;
                     state       <= S_IDLE;
                  end else begin
                     state <= S_SEND;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.uart_transmit = uart_transmit;
   assign bus.uart_tx_byte  = uart_tx_byte;
   assign bus.grant_valid   = grant_valid;
   assign bus.grant_id      = grant_id;
   assign bus.abort         = abort;
endmodule
